// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state type and digit constants for the BCD-to-binary converter
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ADJ   = 2'd2,
        DONE  = 2'd3
    } bcd2bin_state_t;

    localparam int DIGIT_W    = 4;
    localparam int DIGIT_MAX  = 9;
    localparam int ADJ_THRESH = 8;
    localparam int ADJ_VAL    = 3;

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: per-digit reverse double-dabble correction (d >= 8 ? d - 3 : d)
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d_in,
    output logic [DIGIT_W-1:0] d_out
);

    // a digit that picked up a half-weight bit from the digit above is pulled back by 3
    always_comb begin
        d_out = (d_in >= DIGIT_W'(ADJ_THRESH)) ? d_in - DIGIT_W'(ADJ_VAL) : d_in;
    end

endmodule

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential reverse double-dabble BCD-to-binary converter; BCD_TO_BIN_CHECK_EN adds invalid-digit detection
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
    output logic                      busy,
    output logic                      done,
    output logic [BIN_W-1:0]          bin_out,
    output logic                      err
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W) + 1;

    bcd2bin_state_t     state_q, state_d;
    logic [BCD_W-1:0]   bcd_r_q, bcd_r_d, bcd_adj;
    logic [BIN_W-1:0]   bin_r_q, bin_r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_r_q, err_r_d;
    logic [BIN_W-1:0]   bin_out_q, bin_out_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               bad_digit;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_in  (bcd_r_q[i*DIGIT_W +: DIGIT_W]),
            .d_out (bcd_adj[i*DIGIT_W +: DIGIT_W])
        );
    end

`ifdef BCD_TO_BIN_CHECK_EN
    // flag any incoming digit above 9 so the result can be suppressed at the end
    always_comb begin
        bad_digit = 1'b0;
        for (int k = 0; k < DIGITS; k++)
            if (bcd_in[k*DIGIT_W +: DIGIT_W] > DIGIT_W'(DIGIT_MAX))
                bad_digit = 1'b1;
    end
`else
    assign bad_digit = 1'b0;
`endif

    // next-state and datapath: alternate shift and digit correction, then publish
    always_comb begin
        state_d   = state_q;
        bcd_r_d   = bcd_r_q;
        bin_r_d   = bin_r_q;
        cnt_d     = cnt_q;
        err_r_d   = err_r_q;
        bin_out_d = bin_out_q;
        err_d     = err_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bcd_r_d = bcd_in;
                    bin_r_d = '0;
                    cnt_d   = '0;
                    err_r_d = bad_digit;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_r_d, bin_r_d} = {bcd_r_q, bin_r_q} >> 1;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CNT_W'(BIN_W - 1)) ? DONE : ADJ;
            end
            ADJ: begin
                bcd_r_d = bcd_adj;
                state_d = SHIFT;
            end
            DONE: begin
                bin_out_d = err_r_q ? '0 : bin_r_q;
                err_d     = err_r_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers, cleared by the active-low synchronous reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            bcd_r_q   <= '0;
            bin_r_q   <= '0;
            cnt_q     <= '0;
            err_r_q   <= 1'b0;
            bin_out_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_r_q   <= bcd_r_d;
            bin_r_q   <= bin_r_d;
            cnt_q     <= cnt_d;
            err_r_q   <= err_r_d;
            bin_out_q <= bin_out_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign bin_out = bin_out_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: scoreboard bench for bcd_to_bin with directed vectors
module tb_bcd_to_bin;

    typedef struct {
        int bin;
        bit err;
        int cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [11:0] bcd_in = '0;
    logic        busy, done, err;
    logic [9:0]  bin_out;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    bcd_to_bin #(.DIGITS(3), .BIN_W(10)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 bin_out=%0d err=%0d, required no done", bin_out, err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("bin_out", int'(bin_out), e.bin);
                chk("err", int'(err), int'(e.err));
                chk("latency", cyc - e.cyc - 1, 20);
            end
        end
    end

    // issue one conversion; optionally poke bcd_in/start at loop step pk
    task automatic convert(input logic [11:0] b, input int exp_bin, input bit exp_err,
                           input bit now, input int pk, input logic [11:0] pbcd, input bit pstart);
        int  busy_n;
        bit  seen;
        if (!now) @(negedge clk);
        start  = 1'b1;
        bcd_in = b;
        exp_q.push_back('{exp_bin, exp_err, cyc});
        @(negedge clk);
        start  = 1'b0;
        busy_n = 0;
        seen   = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (k == pk) begin
                bcd_in = pbcd;
                start  = pstart;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_n++;
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", int'(seen), 1);
        chk("busy_cycles", busy_n, 20);
    endtask

    task automatic idle_wait(input int n);
        repeat (n) @(negedge clk);
        chk("busy_idle", int'(busy), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_bin_out", int'(bin_out), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b1;

        convert(12'h243, 243, 1'b0, 1'b0, -1, 12'h000, 1'b0);
        idle_wait(2);
        convert(12'h005, 5, 1'b0, 1'b0, -1, 12'h000, 1'b0);
        convert(12'h076, 76, 1'b0, 1'b0, -1, 12'h000, 1'b0);
        convert(12'h198, 198, 1'b0, 1'b0, -1, 12'h000, 1'b0);
        convert(12'h000, 0, 1'b0, 1'b0, -1, 12'h000, 1'b0);
        convert(12'h999, 999, 1'b0, 1'b0, -1, 12'h000, 1'b0);

        convert(12'h243, 243, 1'b0, 1'b0, -1, 12'h000, 1'b0);
        convert(12'h198, 198, 1'b0, 1'b1, -1, 12'h000, 1'b0);

        convert(12'h999, 999, 1'b0, 1'b0, 5, 12'h005, 1'b1);
        convert(12'h005, 5, 1'b0, 1'b0, 12, 12'h243, 1'b1);
        idle_wait(25);

        convert(12'h076, 76, 1'b0, 1'b0, 3, 12'h555, 1'b0);
        idle_wait(2);

        @(negedge clk);
        start  = 1'b1;
        bcd_in = 12'h999;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_bin_out", int'(bin_out), 0);
        chk("abort_err", int'(err), 0);
        chk("abort_done", int'(done), 0);
        idle_wait(30);
        convert(12'h243, 243, 1'b0, 1'b0, -1, 12'h000, 1'b0);

`ifdef BCD_TO_BIN_CHECK_EN
        convert(12'h1A5, 0, 1'b1, 1'b0, -1, 12'h000, 1'b0);
        convert(12'h105, 105, 1'b0, 1'b0, -1, 12'h000, 1'b0);
`endif

        idle_wait(5);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bcd_to_bin.md
# bcd_to_bin

Sequential BCD-to-binary converter using reverse double-dabble: one right shift and one per-digit correction step per output bit. It accepts a packed multi-digit BCD word from the front-panel/keypad side of the TM1638 path and returns the equivalent unsigned binary value. It pairs with the existing binary-to-BCD display conversion, so values entered or shown in decimal can be fed back into binary logic.

## Interface
Parameters:
- DIGITS, 3, number of BCD digits in `bcd_in`.
- BIN_W, 10, binary result width; must satisfy 2^BIN_W > 10^DIGITS − 1. The default 10 covers 0..999.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  conversion request, sampled only in IDLE.
- bcd_in  in  4*DIGITS  packed BCD digits; digit 0 is bits [3:0].
- busy  out  1  high whenever state ≠ IDLE; decoded from the state register.
- done  out  1  one-cycle pulse; `bin_out` is valid from this cycle onward.
- bin_out  out  BIN_W  binary result; holds its value until the next `done`.
- err  out  1  invalid-digit flag, updated together with `done`.

## Operation
- State register: IDLE, SHIFT, ADJ, DONE.
- Working registers:
  - `bcd_r` (4*DIGITS bits)
  - `bin_r` (BIN_W bits)
  - `cnt` ($clog2(BIN_W)+1 bits)
  - `err_r`
- IDLE, start=1:
  - `bcd_r` ← `bcd_in`, `bin_r` ← 0, `cnt` ← 0, `err_r` ← digit check (see Configuration).
  - Next state: SHIFT.
- IDLE, start=0: remain in IDLE; all registers hold.
- SHIFT:
  - Shift {bcd_r, bin_r} right by one as a single word: bcd_r[0] enters bin_r[BIN_W−1]; 0 enters bcd_r MSB.
  - `cnt` ← cnt+1.
  - If cnt == BIN_W−1, go to DONE; otherwise go to ADJ.
- ADJ:
  - Every 4-bit digit of `bcd_r` with value ≥ 8 has 3 subtracted (modulo 16, per digit, no inter-digit borrow).
  - Next state: SHIFT.
- DONE:
  - `bin_out` ← (err_r ? 0 : bin_r), `err` ← err_r, `done` ← 1.
  - Next state: IDLE.
- `done` is cleared in every state other than DONE, so it is a single-cycle pulse.
- `start` while busy: ignored, with no queueing.
- `start` in the cycle `done` is high: accepted, because the state is already IDLE.
- `bcd_in` is sampled only on the accepting edge. Later changes to `bcd_in` do not affect the conversion in flight.
- Reset (rst=0 at a clock edge), including mid-conversion:
  - state ← IDLE; `bcd_r`, `bin_r`, `cnt`, `err_r` ← 0.
  - bin_out ← 0, done ← 0, err ← 0.
  - An aborted conversion never produces `done`.

## Timing
- Accepting edge = edge 0.
- Edge sequence:
  - SHIFT at odd edges 1 … 2·BIN_W−1.
  - ADJ at even edges 2 … 2·BIN_W−2.
  - DONE at edge 2·BIN_W.
- With defaults: `done` and the new `bin_out` are visible exactly 20 cycles after `start` is sampled; `busy` is high for those 20 cycles.
- Minimum start-to-start spacing is 2·BIN_W+1 cycles (21 with defaults).
- All outputs are registered except `busy`, which is a state decode.

## Configuration
- Macro: `BCD_TO_BIN_CHECK_EN`.
- Defined:
  - On accept, `err_r` ← 1 if any digit of `bcd_in` is > 9.
  - The conversion still runs full length; at DONE, `bin_out` is forced to 0 and `err` is set to 1.
- Undefined:
  - No digit-check logic is built; `err_r` and `err` are constant 0.
  - Invalid digits produce an unspecified `bin_out`; timing is unchanged.
- The `err` port is present in both builds.

## Structure
- Package `bcd_pkg`:
  - state enum `bcd2bin_state_t` {IDLE, SHIFT, ADJ, DONE}
  - `DIGIT_W` = 4
  - `DIGIT_MAX` = 9
  - `ADJ_THRESH` = 8
  - `ADJ_VAL` = 3
- Sub-module `bcd_digit_adj`: combinational 4-bit block (d ≥ 8 ? d−3 : d), instantiated DIGITS times in a generate loop and used in ADJ.

## Test plan
- Conversion timing: rst low for 2 cycles, then start with bcd_in=12'h243 → bin_out=243 (8'hF3 zero-extended), done pulses exactly 20 cycles after start, busy high for those 20 cycles, err=0.
- Value sweep, one conversion each:
  - 12'h005 → 5
  - 12'h076 → 76
  - 12'h198 → 198
  - 12'h000 → 0
  - 12'h999 → 999 (10'h3E7)
- Back-to-back and busy handling:
  - start re-asserted in the done cycle with 12'h198 → second done 21 cycles after the first, bin_out=198.
  - start pulses during busy are ignored: no extra done.
- Input stability: change bcd_in to 12'h555 mid-conversion after accepting 12'h076 → bin_out=76.
- Reset abort: assert rst low at cycle 7 of a conversion → busy=0, done never pulses, bin_out=0, err=0; a following 12'h243 conversion returns 243.
- Invalid digit with `BCD_TO_BIN_CHECK_EN` defined: bcd_in=12'h1A5 → done after 20 cycles with err=1, bin_out=0; then 12'h105 → err=0, bin_out=105.
